// File: rtl/multicycle_control_unit.sv
// Multi-cycle main controller for the MIPS datapath.
// A Moore FSM sequences fetch/decode/execute/memory/write-back and
// stalls on the memory-ready handshake, with an optional timeout.
// It also flags illegal opcodes and counts retired instructions.
module multicycle_control_unit #(
  parameter int MEM_WAIT        = 1,
  parameter int MEM_TIMEOUT     = 16,
  parameter int HALT_ON_ILLEGAL = 1,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             branch_ne,
  output logic [1:0]       pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EX     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  // Wide enough to reach MEM_TIMEOUT without wrapping, and at least one bit.
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);

  state_t            state_q;
  logic              bne_q;
  logic              jal_q;
  logic              lw_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              rdy;
  logic              mem_state;
  logic              timeout_hit;
  logic              opc_legal;

  // With MEM_WAIT off every access completes at once, so mem_ready is ignored.
  assign rdy       = (MEM_WAIT != 0) ? mem_ready : 1'b1;
  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  // A ready in the last allowed wait cycle still wins over the timeout.
  assign timeout_hit = (MEM_TIMEOUT > 0) && mem_state && !rdy &&
                       (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
  assign opc_legal = (opcode == 6'h00) || (opcode == 6'h23) || (opcode == 6'h2B) ||
                     (opcode == 6'h04) || (opcode == 6'h05) || (opcode == 6'h02) ||
                     (opcode == 6'h03) || (opcode == 6'h08);
  assign state     = state_q;

  // State sequencing, decode latches, wait counter, sticky fault and retire counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      bne_q       <= 1'b0;
      jal_q       <= 1'b0;
      lw_q        <= 1'b0;
      wait_cnt    <= '0;
      fault       <= 2'b00;
      instr_count <= '0;
    end else begin
      if (instr_done) instr_count <= instr_count + 1'b1;
      if (timeout_hit) begin
        state_q  <= S_HALT;
        fault    <= 2'b10;
        wait_cnt <= '0;
      end else begin
        if (mem_state && !rdy) wait_cnt <= wait_cnt + 1'b1;
        else                   wait_cnt <= '0;
        case (state_q)
          S_FETCH:    if (rdy) state_q <= S_DECODE;
          S_DECODE: begin
            bne_q <= (opcode == 6'h05);
            jal_q <= (opcode == 6'h03);
            lw_q  <= (opcode == 6'h23);
            case (opcode)
              6'h00:        state_q <= S_R_EX;
              6'h23, 6'h2B: state_q <= S_MEM_ADDR;
              6'h04, 6'h05: state_q <= S_BRANCH;
              6'h02, 6'h03: state_q <= S_JUMP;
              6'h08:        state_q <= S_ADDI_EX;
              default: begin
                if (HALT_ON_ILLEGAL != 0) begin
                  state_q <= S_HALT;
                  fault   <= 2'b01;
                end else begin
                  state_q <= S_FETCH;
                end
              end
            endcase
          end
          S_MEM_ADDR: state_q <= lw_q ? S_MEM_RD : S_MEM_WR;
          S_MEM_RD:   if (rdy) state_q <= S_MEM_WB;
          S_MEM_WR:   if (rdy) state_q <= S_FETCH;
          S_R_EX:     state_q <= S_R_WB;
          S_ADDI_EX:  state_q <= S_ADDI_WB;
          S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: state_q <= S_FETCH;
          S_HALT:     state_q <= S_HALT;
          default: begin
            state_q <= S_HALT;
            fault   <= 2'b01;
          end
        endcase
      end
    end
  end

  // Moore control decode; only the fetch/store handshake strobes look at rdy.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = rdy;
        pc_write  = rdy;
      end
      S_DECODE: begin
        alu_src_b  = 2'b11;
        illegal_op = !opc_legal;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = rdy;
      end
      S_R_EX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 2'b01;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        branch_ne     = bne_q;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
        if (jal_q) begin
          reg_write  = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
        end
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed testbench for multicycle_control_unit.
// Instance a: MEM_WAIT=1, MEM_TIMEOUT=4, HALT_ON_ILLEGAL=1, CNT_W=32.
// Instance b: MEM_WAIT=0, HALT_ON_ILLEGAL=0, CNT_W=4.
module tb_multicycle_control_unit;

  logic clk = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic       a_reset, a_mem_ready;
  logic [5:0] a_opcode;
  logic       a_pc_write, a_pc_write_cond, a_branch_ne, a_i_or_d, a_mem_read, a_mem_write;
  logic       a_ir_write, a_reg_write, a_alu_src_a, a_instr_done, a_illegal_op;
  logic [1:0] a_pc_source, a_reg_dst, a_mem_to_reg, a_alu_src_b, a_alu_op, a_fault;
  logic [3:0] a_state;
  logic [31:0] a_instr_count;

  logic       b_reset, b_mem_ready;
  logic [5:0] b_opcode;
  logic       b_pc_write, b_pc_write_cond, b_branch_ne, b_i_or_d, b_mem_read, b_mem_write;
  logic       b_ir_write, b_reg_write, b_alu_src_a, b_instr_done, b_illegal_op;
  logic [1:0] b_pc_source, b_reg_dst, b_mem_to_reg, b_alu_src_b, b_alu_op, b_fault;
  logic [3:0] b_state;
  logic [3:0] b_instr_count;

  multicycle_control_unit #(.MEM_WAIT(1), .MEM_TIMEOUT(4), .HALT_ON_ILLEGAL(1), .CNT_W(32)) dut_a (
    .clk(clk), .reset(a_reset), .opcode(a_opcode), .mem_ready(a_mem_ready),
    .pc_write(a_pc_write), .pc_write_cond(a_pc_write_cond), .branch_ne(a_branch_ne),
    .pc_source(a_pc_source), .i_or_d(a_i_or_d), .mem_read(a_mem_read), .mem_write(a_mem_write),
    .ir_write(a_ir_write), .reg_write(a_reg_write), .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg),
    .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .alu_op(a_alu_op), .state(a_state),
    .instr_done(a_instr_done), .illegal_op(a_illegal_op), .fault(a_fault), .instr_count(a_instr_count)
  );

  multicycle_control_unit #(.MEM_WAIT(0), .MEM_TIMEOUT(16), .HALT_ON_ILLEGAL(0), .CNT_W(4)) dut_b (
    .clk(clk), .reset(b_reset), .opcode(b_opcode), .mem_ready(b_mem_ready),
    .pc_write(b_pc_write), .pc_write_cond(b_pc_write_cond), .branch_ne(b_branch_ne),
    .pc_source(b_pc_source), .i_or_d(b_i_or_d), .mem_read(b_mem_read), .mem_write(b_mem_write),
    .ir_write(b_ir_write), .reg_write(b_reg_write), .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg),
    .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .alu_op(b_alu_op), .state(b_state),
    .instr_done(b_instr_done), .illegal_op(b_illegal_op), .fault(b_fault), .instr_count(b_instr_count)
  );

  // Free-running clock shared by both instances.
  always #5 clk = ~clk;

  // Advance one cycle and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_reset = 1'b1; a_mem_ready = 1'b0; a_opcode = 6'h00;
    b_reset = 1'b1; b_mem_ready = 1'b0; b_opcode = 6'h00;
    tick();
    checks++; if (a_state !== 4'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", a_state); end
    checks++; if (a_mem_read !== 1'b1 || a_alu_src_b !== 2'b01) begin errors++; $display("[TB] FAIL reset_fetch_outs: got mem_read=%b alu_src_b=%b expected 1/01", a_mem_read, a_alu_src_b); end
    checks++; if (a_ir_write !== 1'b0 || a_pc_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_not_ready: got ir_write=%b pc_write=%b expected 0/0", a_ir_write, a_pc_write); end
    checks++; if (a_fault !== 2'b00 || a_instr_count !== 32'd0) begin errors++; $display("[TB] FAIL reset_fault_count: got fault=%b count=%0d expected 00/0", a_fault, a_instr_count); end
    checks++; if (a_reg_write !== 1'b0 || a_mem_write !== 1'b0 || a_instr_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_others: got reg_write=%b mem_write=%b done=%b expected 0", a_reg_write, a_mem_write, a_instr_done); end
    a_mem_ready = 1'b1;
    #1;
    checks++; if (a_ir_write !== 1'b1 || a_pc_write !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got ir_write=%b pc_write=%b expected 1/1", a_ir_write, a_pc_write); end
    checks++; if (b_ir_write !== 1'b1) begin errors++; $display("[TB] FAIL reset_nowait_irw: got %b expected 1", b_ir_write); end
    a_reset = 1'b0;
  endtask

  task automatic test_rtype();
    int exp_s[5] = '{0, 1, 6, 7, 0};
    int dones = 0;
    b_reset = 1'b0; b_opcode = 6'h00;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      checks++; if (b_state !== 4'(exp_s[i])) begin errors++; $display("[TB] FAIL rtype_state[%0d]: got %0d expected %0d", i, b_state, exp_s[i]); end
      if (i == 2) begin
        checks++; if (b_alu_op !== 2'b10 || b_alu_src_a !== 1'b1) begin errors++; $display("[TB] FAIL rtype_ex: got alu_op=%b src_a=%b expected 10/1", b_alu_op, b_alu_src_a); end
      end
      if (i == 3) begin
        checks++; if (b_reg_dst !== 2'b01 || b_reg_write !== 1'b1) begin errors++; $display("[TB] FAIL rtype_wb: got reg_dst=%b reg_write=%b expected 01/1", b_reg_dst, b_reg_write); end
      end
      if (b_instr_done === 1'b1) dones++;
    end
    checks++; if (dones != 1) begin errors++; $display("[TB] FAIL rtype_done_pulses: got %0d expected 1", dones); end
    checks++; if (b_instr_count !== 4'd1) begin errors++; $display("[TB] FAIL rtype_count: got %0d expected 1", b_instr_count); end
  endtask

  task automatic test_lw_wait();
    a_opcode = 6'h23; a_mem_ready = 1'b1;
    checks++; if (a_state !== 4'd0) begin errors++; $display("[TB] FAIL lw_start: got %0d expected 0", a_state); end
    tick();
    checks++; if (a_state !== 4'd1 || a_alu_src_b !== 2'b11) begin errors++; $display("[TB] FAIL lw_decode: got state=%0d src_b=%b expected 1/11", a_state, a_alu_src_b); end
    tick();
    checks++; if (a_state !== 4'd2 || a_alu_src_a !== 1'b1 || a_alu_src_b !== 2'b10) begin errors++; $display("[TB] FAIL lw_addr: got state=%0d src_a=%b src_b=%b expected 2/1/10", a_state, a_alu_src_a, a_alu_src_b); end
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin tick(); a_mem_ready = 1'b0; end
      else tick();
      if (i == 3) a_mem_ready = 1'b1;
      #1;
      checks++; if (a_state !== 4'd3 || a_mem_read !== 1'b1 || a_i_or_d !== 1'b1) begin errors++; $display("[TB] FAIL lw_rd_hold[%0d]: got state=%0d mem_read=%b i_or_d=%b expected 3/1/1", i, a_state, a_mem_read, a_i_or_d); end
      checks++; if (a_instr_done !== 1'b0) begin errors++; $display("[TB] FAIL lw_rd_done[%0d]: got %b expected 0", i, a_instr_done); end
    end
    tick();
    checks++; if (a_state !== 4'd4 || a_mem_to_reg !== 2'b01 || a_reg_write !== 1'b1 || a_reg_dst !== 2'b00 || a_instr_done !== 1'b1) begin errors++; $display("[TB] FAIL lw_wb: got state=%0d m2r=%b rw=%b dst=%b done=%b expected 4/01/1/00/1", a_state, a_mem_to_reg, a_reg_write, a_reg_dst, a_instr_done); end
    tick();
    checks++; if (a_state !== 4'd0 || a_instr_count !== 32'd1) begin errors++; $display("[TB] FAIL lw_end: got state=%0d count=%0d expected 0/1", a_state, a_instr_count); end
  endtask

  task automatic test_bne_jal_sw();
    a_opcode = 6'h05;
    tick(); tick();
    checks++; if (a_state !== 4'd8 || a_pc_write_cond !== 1'b1 || a_branch_ne !== 1'b1 || a_pc_source !== 2'b01 || a_alu_op !== 2'b01) begin errors++; $display("[TB] FAIL bne: got state=%0d pwc=%b bne=%b psrc=%b aluop=%b expected 8/1/1/01/01", a_state, a_pc_write_cond, a_branch_ne, a_pc_source, a_alu_op); end
    a_opcode = 6'h03;
    tick(); tick(); tick();
    checks++; if (a_state !== 4'd9 || a_pc_write !== 1'b1 || a_pc_source !== 2'b10) begin errors++; $display("[TB] FAIL jal_pc: got state=%0d pw=%b psrc=%b expected 9/1/10", a_state, a_pc_write, a_pc_source); end
    checks++; if (a_reg_dst !== 2'b10 || a_mem_to_reg !== 2'b10 || a_reg_write !== 1'b1 || a_branch_ne !== 1'b0) begin errors++; $display("[TB] FAIL jal_link: got dst=%b m2r=%b rw=%b bne=%b expected 10/10/1/0", a_reg_dst, a_mem_to_reg, a_reg_write, a_branch_ne); end
    a_opcode = 6'h2B;
    tick(); tick(); tick(); tick();
    checks++; if (a_state !== 4'd5 || a_mem_write !== 1'b1 || a_i_or_d !== 1'b1 || a_instr_done !== 1'b1) begin errors++; $display("[TB] FAIL sw: got state=%0d mw=%b iod=%b done=%b expected 5/1/1/1", a_state, a_mem_write, a_i_or_d, a_instr_done); end
    tick();
    checks++; if (a_state !== 4'd0 || a_instr_count !== 32'd4) begin errors++; $display("[TB] FAIL sw_end: got state=%0d count=%0d expected 0/4", a_state, a_instr_count); end
  endtask

  task automatic test_fetch_ready_late();
    a_opcode = 6'h08; a_mem_ready = 1'b0;
    tick(); tick(); tick();
    a_mem_ready = 1'b1;
    #1;
    checks++; if (a_state !== 4'd0 || a_ir_write !== 1'b1 || a_fault !== 2'b00) begin errors++; $display("[TB] FAIL late_ready: got state=%0d irw=%b fault=%b expected 0/1/00", a_state, a_ir_write, a_fault); end
    tick();
    checks++; if (a_state !== 4'd1) begin errors++; $display("[TB] FAIL late_decode: got %0d expected 1", a_state); end
    tick(); tick();
    checks++; if (a_state !== 4'd11 || a_reg_write !== 1'b1 || a_reg_dst !== 2'b00) begin errors++; $display("[TB] FAIL addi_wb: got state=%0d rw=%b dst=%b expected 11/1/00", a_state, a_reg_write, a_reg_dst); end
    tick();
    checks++; if (a_instr_count !== 32'd5) begin errors++; $display("[TB] FAIL addi_count: got %0d expected 5", a_instr_count); end
  endtask

  task automatic test_reset_abort();
    a_opcode = 6'h23;
    tick(); tick(); tick();
    a_reset = 1'b1;
    #1;
    checks++; if (a_state !== 4'd0 || a_instr_count !== 32'd0) begin errors++; $display("[TB] FAIL abort: got state=%0d count=%0d expected 0/0", a_state, a_instr_count); end
    a_reset = 1'b0;
  endtask

  task automatic test_illegal_halt();
    a_opcode = 6'h3F;
    tick();
    checks++; if (a_illegal_op !== 1'b1) begin errors++; $display("[TB] FAIL illegal_pulse: got %b expected 1", a_illegal_op); end
    tick();
    checks++; if (a_state !== 4'd12 || a_fault !== 2'b01 || a_illegal_op !== 1'b0) begin errors++; $display("[TB] FAIL illegal_halt: got state=%0d fault=%b ill=%b expected 12/01/0", a_state, a_fault, a_illegal_op); end
    a_opcode = 6'h00;
    tick(); tick();
    checks++; if (a_state !== 4'd12 || a_fault !== 2'b01 || a_instr_count !== 32'd0 || a_mem_read !== 1'b0) begin errors++; $display("[TB] FAIL halt_sticky: got state=%0d fault=%b count=%0d mr=%b expected 12/01/0/0", a_state, a_fault, a_instr_count, a_mem_read); end
    a_reset = 1'b1;
    #1;
    checks++; if (a_state !== 4'd0 || a_fault !== 2'b00) begin errors++; $display("[TB] FAIL halt_reset: got state=%0d fault=%b expected 0/00", a_state, a_fault); end
    a_reset = 1'b0;
  endtask

  task automatic test_timeout();
    a_mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (a_state !== 4'd0 || a_fault !== 2'b00) begin errors++; $display("[TB] FAIL timeout_wait[%0d]: got state=%0d fault=%b expected 0/00", i, a_state, a_fault); end
    end
    tick();
    checks++; if (a_state !== 4'd12 || a_fault !== 2'b10) begin errors++; $display("[TB] FAIL timeout_halt: got state=%0d fault=%b expected 12/10", a_state, a_fault); end
  endtask

  task automatic test_illegal_skip();
    b_opcode = 6'h3F;
    tick();
    checks++; if (b_state !== 4'd1 || b_illegal_op !== 1'b1) begin errors++; $display("[TB] FAIL skip_pulse: got state=%0d ill=%b expected 1/1", b_state, b_illegal_op); end
    tick();
    checks++; if (b_state !== 4'd0 || b_fault !== 2'b00 || b_instr_count !== 4'd1) begin errors++; $display("[TB] FAIL skip_fetch: got state=%0d fault=%b count=%0d expected 0/00/1", b_state, b_fault, b_instr_count); end
  endtask

  task automatic test_count_wrap();
    b_reset = 1'b1;
    #1;
    checks++; if (b_instr_count !== 4'd0) begin errors++; $display("[TB] FAIL wrap_reset: got %0d expected 0", b_instr_count); end
    b_reset = 1'b0; b_opcode = 6'h08;
    for (int k = 1; k <= 17; k++) begin
      tick(); tick(); tick();
      checks++; if (b_state !== 4'd11) begin errors++; $display("[TB] FAIL wrap_wb_state[%0d]: got %0d expected 11", k, b_state); end
      tick();
      checks++; if (b_state !== 4'd0 || b_instr_count !== 4'(k % 16)) begin errors++; $display("[TB] FAIL wrap_count[%0d]: got state=%0d count=%0d expected 0/%0d", k, b_state, b_instr_count, k % 16); end
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_lw_wait();
    test_bne_jal_sw();
    test_fetch_ready_late();
    test_reset_abort();
    test_illegal_halt();
    test_timeout();
    test_rtype();
    test_illegal_skip();
    test_count_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
